// File: rtl/regfile_write_arbiter.sv
// Two-source register-file writeback arbiter (ALU and load unit).
// Grants one source per cycle and commits its write on the next cycle, with byte masks for narrow loads.
module regfile_write_arbiter (
   input  logic        clk,
   input  logic        reset,
   input  logic        alu_req,
   input  logic [4:0]  alu_rd,
   input  logic [31:0] alu_data,
   input  logic        mem_req,
   input  logic [4:0]  mem_rd,
   input  logic [31:0] mem_data,
   input  logic [5:0]  mem_opcode,
   output logic        alu_ack,
   output logic        mem_ack,
   output logic        wr_en,
   output logic [4:0]  wr_addr,
   output logic [31:0] wr_data,
   output logic [3:0]  wr_mask,
   output logic [15:0] wr_count
);

   localparam int unsigned RD_W   = 5;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned MASK_W = 4;
   localparam int unsigned OP_W   = 6;
   localparam int unsigned CNT_W  = 16;

   localparam logic [OP_W-1:0]   OP_LB    = OP_W'(6'h24);
   localparam logic [OP_W-1:0]   OP_LH    = OP_W'(6'h25);
   localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [MASK_W-1:0] MASK_ALL = {MASK_W{1'b1}};

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WR_ALU = 2'd1,
      WR_MEM = 2'd2
   } state_t;

   state_t            state;
   state_t            next_state;
   logic              alu_first_q;
   logic              alu_first;
   logic              commit;
   logic [RD_W-1:0]   commit_rd;
   logic [DATA_W-1:0] commit_data;
   logic [MASK_W-1:0] commit_mask;
   logic [MASK_W-1:0] mem_mask;

   // State register and round-robin pointer
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         alu_first_q <= 1'b1;
      end else begin
         state       <= next_state;
         alu_first_q <= alu_first;
      end
   end

   // Arbitration: the grant decided here is the state committed next cycle.
   // The pointer folds in the grant currently committing so a loser wins the very next cycle.
   always_comb begin
      next_state = IDLE;
      alu_ack    = 1'b0;
      mem_ack    = 1'b0;
      alu_first  = alu_first_q;
      case (state)
         WR_ALU:  alu_first = 1'b0;
         WR_MEM:  alu_first = 1'b1;
         default: alu_first = alu_first_q;
      endcase
      if (!reset) begin
         if (alu_req && mem_req) begin
            // Same destination: load goes first so the ALU value lands last
            if ((alu_rd == mem_rd) || !alu_first) next_state = WR_MEM;
            else                                  next_state = WR_ALU;
         end else if (alu_req) begin
            next_state = WR_ALU;
         end else if (mem_req) begin
            next_state = WR_MEM;
         end
      end
      alu_ack = (next_state == WR_ALU);
      mem_ack = (next_state == WR_MEM);
   end

   // Byte enables for narrow loads; data is never shifted
   always_comb begin
      mem_mask = MASK_ALL;
      if (mem_opcode == OP_LB)      mem_mask = MASK_W'(4'b0001);
      else if (mem_opcode == OP_LH) mem_mask = MASK_W'(4'b0011);
   end

   assign commit_rd   = (next_state == WR_ALU) ? alu_rd   : mem_rd;
   assign commit_data = (next_state == WR_ALU) ? alu_data : mem_data;
   assign commit_mask = (next_state == WR_ALU) ? MASK_ALL : mem_mask;
   assign commit      = (next_state != IDLE) && (commit_rd != RD_W'(0));

   // Registered write port; address/data/mask hold when nothing is written
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         wr_mask  <= '0;
         wr_count <= '0;
      end else begin
         wr_en <= commit;
         if (commit) begin
            wr_addr <= commit_rd;
            wr_data <= commit_data;
            wr_mask <= commit_mask;
            if (wr_count != CNT_MAX) wr_count <= wr_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: a per-cycle vector table followed by
// hand-written reset and arbitration sequences.
module tb_regfile_write_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        alu_req;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        mem_req;
   logic [4:0]  mem_rd;
   logic [31:0] mem_data;
   logic [5:0]  mem_opcode;
   logic        alu_ack;
   logic        mem_ack;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [3:0]  wr_mask;
   logic [15:0] wr_count;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   regfile_write_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .alu_req    (alu_req),
      .alu_rd     (alu_rd),
      .alu_data   (alu_data),
      .mem_req    (mem_req),
      .mem_rd     (mem_rd),
      .mem_data   (mem_data),
      .mem_opcode (mem_opcode),
      .alu_ack    (alu_ack),
      .mem_ack    (mem_ack),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .wr_mask    (wr_mask),
      .wr_count   (wr_count)
   );

   typedef struct {
      logic        ar;
      logic [4:0]  ard;
      logic [31:0] adata;
      logic        mr;
      logic [4:0]  mrd;
      logic [31:0] mdata;
      logic [5:0]  mop;
      logic        e_aack;
      logic        e_mack;
      logic        e_en;
      logic [4:0]  e_addr;
      logic [31:0] e_data;
      logic [3:0]  e_mask;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      alu_req    = v.ar;
      alu_rd     = v.ard;
      alu_data   = v.adata;
      mem_req    = v.mr;
      mem_rd     = v.mrd;
      mem_data   = v.mdata;
      mem_opcode = v.mop;
   endtask

   task automatic idle_inputs();
      alu_req = 1'b0; alu_rd = '0; alu_data = '0;
      mem_req = 1'b0; mem_rd = '0; mem_data = '0; mem_opcode = '0;
   endtask

   initial begin
      // ar ard adata         mr mrd mdata         mop     aack mack en addr data          mask     cnt
      vecs[0]  = '{1, 5'd5,  32'h1234_5678, 0, 5'd0,  32'h0,         6'h00, 1, 0, 1, 5'd5,  32'h1234_5678, 4'b1111, 16'd1};
      vecs[1]  = '{0, 5'd0,  32'h0,         0, 5'd0,  32'h0,         6'h00, 0, 0, 0, 5'd5,  32'h1234_5678, 4'b1111, 16'd1};
      vecs[2]  = '{0, 5'd0,  32'h0,         1, 5'd9,  32'hAABB_CCDD, 6'h24, 0, 1, 1, 5'd9,  32'hAABB_CCDD, 4'b0001, 16'd2};
      vecs[3]  = '{0, 5'd0,  32'h0,         1, 5'd10, 32'h1122_3344, 6'h25, 0, 1, 1, 5'd10, 32'h1122_3344, 4'b0011, 16'd3};
      vecs[4]  = '{0, 5'd0,  32'h0,         1, 5'd11, 32'h5566_7788, 6'h23, 0, 1, 1, 5'd11, 32'h5566_7788, 4'b1111, 16'd4};
      vecs[5]  = '{1, 5'd20, 32'h0000_0020, 1, 5'd21, 32'h0000_0021, 6'h00, 1, 0, 1, 5'd20, 32'h0000_0020, 4'b1111, 16'd5};
      vecs[6]  = '{0, 5'd0,  32'h0,         1, 5'd21, 32'h0000_0021, 6'h00, 0, 1, 1, 5'd21, 32'h0000_0021, 4'b1111, 16'd6};
      vecs[7]  = '{1, 5'd7,  32'hA7A7_A7A7, 1, 5'd7,  32'h3F3F_3F3F, 6'h24, 0, 1, 1, 5'd7,  32'h3F3F_3F3F, 4'b0001, 16'd7};
      vecs[8]  = '{1, 5'd7,  32'hA7A7_A7A7, 0, 5'd0,  32'h0,         6'h00, 1, 0, 1, 5'd7,  32'hA7A7_A7A7, 4'b1111, 16'd8};
      vecs[9]  = '{1, 5'd0,  32'hDEAD_BEEF, 0, 5'd0,  32'h0,         6'h00, 1, 0, 0, 5'd7,  32'hA7A7_A7A7, 4'b1111, 16'd8};
      vecs[10] = '{1, 5'd1,  32'h0000_0001, 1, 5'd2,  32'h0000_0002, 6'h00, 0, 1, 1, 5'd2,  32'h0000_0002, 4'b1111, 16'd9};
      vecs[11] = '{1, 5'd1,  32'h0000_0001, 0, 5'd0,  32'h0,         6'h00, 1, 0, 1, 5'd1,  32'h0000_0001, 4'b1111, 16'd10};
      vecs[12] = '{0, 5'd0,  32'h0,         0, 5'd0,  32'h0,         6'h00, 0, 0, 0, 5'd1,  32'h0000_0001, 4'b1111, 16'd10};

      reset = 1'b1;
      idle_inputs();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Vector table: one arbitration cycle per entry, then the commit it produces
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         drive(vecs[i]);
         #1;
         check($sformatf("v%0d alu_ack", i), 32'(alu_ack), 32'(vecs[i].e_aack));
         check($sformatf("v%0d mem_ack", i), 32'(mem_ack), 32'(vecs[i].e_mack));
         @(posedge clk);
         #1;
         check($sformatf("v%0d wr_en", i),    32'(wr_en),    32'(vecs[i].e_en));
         check($sformatf("v%0d wr_addr", i),  32'(wr_addr),  32'(vecs[i].e_addr));
         check($sformatf("v%0d wr_data", i),  wr_data,       vecs[i].e_data);
         check($sformatf("v%0d wr_mask", i),  32'(wr_mask),  32'(vecs[i].e_mask));
         check($sformatf("v%0d wr_count", i), 32'(wr_count), 32'(vecs[i].e_cnt));
      end

      // Reset clears everything immediately and masks a pending request
      @(negedge clk);
      reset = 1'b1;
      alu_req = 1'b1; alu_rd = 5'd3;
      #1;
      check("rst alu_ack",  32'(alu_ack),  32'd0);
      check("rst mem_ack",  32'(mem_ack),  32'd0);
      check("rst wr_en",    32'(wr_en),    32'd0);
      check("rst wr_addr",  32'(wr_addr),  32'd0);
      check("rst wr_data",  wr_data,       32'd0);
      check("rst wr_mask",  32'(wr_mask),  32'd0);
      check("rst wr_count", 32'(wr_count), 32'd0);

      // Both held after reset: ALU first, MEM the next cycle
      @(negedge clk);
      reset = 1'b0;
      alu_req = 1'b1; alu_rd = 5'd3; alu_data = 32'h0000_0033;
      mem_req = 1'b1; mem_rd = 5'd4; mem_data = 32'h0000_0044; mem_opcode = 6'h00;
      #1;
      check("rr0 alu_ack", 32'(alu_ack), 32'd1);
      check("rr0 mem_ack", 32'(mem_ack), 32'd0);
      @(posedge clk); #1;
      check("rr1 wr_en",    32'(wr_en),    32'd1);
      check("rr1 wr_addr",  32'(wr_addr),  32'd3);
      check("rr1 wr_data",  wr_data,       32'h0000_0033);
      check("rr1 wr_count", 32'(wr_count), 32'd1);
      @(negedge clk);
      alu_req = 1'b0;
      #1;
      check("rr1 mem_ack", 32'(mem_ack), 32'd1);
      check("rr1 alu_ack", 32'(alu_ack), 32'd0);
      @(posedge clk); #1;
      check("rr2 wr_en",    32'(wr_en),    32'd1);
      check("rr2 wr_addr",  32'(wr_addr),  32'd4);
      check("rr2 wr_data",  wr_data,       32'h0000_0044);
      check("rr2 wr_count", 32'(wr_count), 32'd2);
      @(negedge clk);
      idle_inputs();
      @(posedge clk); #1;
      check("rr3 wr_en", 32'(wr_en), 32'd0);

      // Reset pulsed during the commit cycle kills the write strobe
      @(negedge clk);
      alu_req = 1'b1; alu_rd = 5'd6; alu_data = 32'h0000_0066;
      #1;
      check("rc alu_ack", 32'(alu_ack), 32'd1);
      @(posedge clk); #1;
      check("rc wr_en before",    32'(wr_en),    32'd1);
      check("rc wr_count before", 32'(wr_count), 32'd3);
      #1 reset = 1'b1;
      #1;
      check("rc wr_en",    32'(wr_en),    32'd0);
      check("rc wr_count", 32'(wr_count), 32'd0);
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      check("rc after wr_en",    32'(wr_en),    32'd0);
      check("rc after wr_count", 32'(wr_count), 32'd0);

      // Reset between grant and commit drops the pending write
      @(negedge clk);
      alu_req = 1'b1; alu_rd = 5'd8; alu_data = 32'h0000_0088;
      #1;
      check("rg alu_ack", 32'(alu_ack), 32'd1);
      #1 reset = 1'b1;
      #1;
      check("rg alu_ack in reset", 32'(alu_ack), 32'd0);
      @(posedge clk); #1;
      check("rg wr_en",    32'(wr_en),    32'd0);
      check("rg wr_count", 32'(wr_count), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      idle_inputs();
      @(posedge clk); #1;
      check("rg after wr_en",    32'(wr_en),    32'd0);
      check("rg after wr_count", 32'(wr_count), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
